// File: rtl/wbs_ram.sv
// Wishbone B4 classic-cycle slave over a word-addressed RAM; WBS_RAM_ERR_EN turns out-of-range accesses into err instead of wrapping.
// Latency: ack/err pulse for one cycle, WAIT_STATES+1 cycles after IDLE samples cyc&stb; one transfer per WAIT_STATES+2 cycles.
// Backpressure: the master holds stb until terminated; dropping cyc during wait states aborts the transfer.
module wbs_ram #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    input  logic [3:0]            wbs_sel_i,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o
);

    localparam int WW = ADDR_WIDTH - 2;
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WW-1:0]         hadr_q, hadr_d;
    logic                  hwe_q, hwe_d;
    logic [3:0]            hsel_q, hsel_d;
    logic [DATA_WIDTH-1:0] hdat_q, hdat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dato_q, dato_d;

    logic                  req;
    logic                  fire;
    logic                  term_err;
    logic                  wr_en;
    logic [WW-1:0]         acc_widx;
    logic                  acc_we;
    logic [3:0]            acc_sel;
    logic [DATA_WIDTH-1:0] acc_dat;
    logic                  acc_oor;
    logic [IW-1:0]         acc_idx;
    logic                  unused_ok;

    assign req = wbs_cyc_i & wbs_stb_i;

    // With zero wait states the terminating edge is also the capture edge, so use live inputs then.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_widx = wbs_adr_i[ADDR_WIDTH-1:2];
            acc_we   = wbs_we_i;
            acc_sel  = wbs_sel_i;
            acc_dat  = wbs_dat_i;
        end else begin
            acc_widx = hadr_q;
            acc_we   = hwe_q;
            acc_sel  = hsel_q;
            acc_dat  = hdat_q;
        end
    end

    assign acc_oor = (acc_widx >= WW'(DEPTH_WORDS));
    assign acc_idx = acc_widx[IW-1:0];

`ifdef WBS_RAM_ERR_EN
    assign term_err  = acc_oor;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0]};
`else
    assign term_err  = 1'b0;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0], acc_oor};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hadr_d  = hadr_q;
        hwe_d   = hwe_q;
        hsel_d  = hsel_q;
        hdat_d  = hdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dato_d  = dato_q;
        fire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    hadr_d = wbs_adr_i[ADDR_WIDTH-1:2];
                    hwe_d  = wbs_we_i;
                    hsel_d = wbs_sel_i;
                    hdat_d = wbs_dat_i;
                    if (WAIT_STATES == 0) begin
                        fire    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    fire    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // stb still high here belongs to the transfer just terminated
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            if (term_err) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (!acc_we) begin
                    dato_d = mem[acc_idx];
                end
            end
        end
    end

    assign wr_en = fire & acc_we & ~term_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            hadr_q  <= '0;
            hwe_q   <= 1'b0;
            hsel_q  <= 4'd0;
            hdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dato_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hadr_q  <= hadr_d;
            hwe_q   <= hwe_d;
            hsel_q  <= hsel_d;
            hdat_q  <= hdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dato_q  <= dato_d;
        end
    end

    // RAM contents survive reset; reset only suppresses a commit on its edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
                end
            end
        end
    end

    assign wbs_dat_o = dato_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;

endmodule

// File: tb/tb_wbs_ram.sv
// Drives two wbs_ram instances (0 and 3 wait states) with directed transfers checked against a RAM model and scoreboard.
module tb_wbs_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] dat_o [2];
    logic [1:0]  ack;
    logic [1:0]  err;

    always #5 clk = ~clk;

    wbs_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel),
        .wbs_dat_o(dat_o[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0])
    );

    wbs_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_sel_i(sel),
        .wbs_dat_o(dat_o[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1])
    );

    typedef struct {
        int          lat;
        bit          is_err;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [int];
    logic [31:0] last_dat [2];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One transfer on instance i; the expectation is queued before the request is driven.
    task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit scramble);
        exp_t        e;
        exp_t        got;
        logic [29:0] widx;
        bit          oor;
        int          key;
        int          k;
        logic [31:0] old;
        widx = a[31:2];
        oor  = (widx >= 30'd1024);
`ifdef WBS_RAM_ERR_EN
        e.is_err = oor;
`else
        e.is_err = 1'b0;
`endif
        key = i * 1024 + int'(widx % 30'd1024);
        if (!e.is_err) begin
            if (wr) begin
                old = mdl[key];
                for (int b = 0; b < 4; b++)
                    if (s[b]) old[8*b +: 8] = d[8*b +: 8];
                mdl[key] = old;
            end else begin
                last_dat[i] = mdl[key];
            end
        end
        e.dat = last_dat[i];
        e.lat = (i == 0) ? 1 : 4;
        sb.push_back(e);

        @(negedge clk);
        cyc[i] = 1'b1; stb[i] = 1'b1;
        we = wr; adr = a; dat = d; sel = s;
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (ack[i] || err[i]) break;
            if (scramble && k == 1) begin
                we = ~wr; adr = a ^ 32'h8; dat = ~d; sel = ~s;
            end
        end
        got = sb.pop_front();
        if (!(ack[i] || err[i])) begin
            total++;
            bad++;
            $error("FAIL timeout inst=%0d observed=no_termination expected=termination", i);
        end else begin
            chk("latency", 32'(k), 32'(got.lat));
            chk("err", 32'(err[i]), 32'(got.is_err));
            chk("ack", 32'(ack[i]), 32'(!got.is_err));
            chk("dat_o", dat_o[i], got.dat);
        end
        // stb stays asserted through the response cycle; no second termination may follow
        @(posedge clk); #1;
        chk("single_pulse", 32'(ack[i] | err[i]), 32'd0);
        @(negedge clk);
        cyc[i] = 1'b0; stb[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 2'b00; stb = 2'b00;
        we = 1'b0; adr = '0; dat = '0; sel = '0;
        last_dat[0] = '0; last_dat[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", 32'(ack[i]), 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
            chk("rst_dat", dat_o[i], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // zero wait states: full write, read, byte lanes, empty sel
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        chk("lane_merge", dat_o[0], 32'hDE22BE44);
        xfer(0, 1'b1, 32'h10, 32'h55667788, 4'b0000, 1'b0);
        xfer(0, 1'b0, 32'h13, 32'h0, 4'h2, 1'b0);

        // three wait states; inputs scrambled during WAIT must be ignored
        xfer(1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        xfer(1, 1'b1, 32'h24, 32'h600DCAFE, 4'hF, 1'b1);
        xfer(1, 1'b1, 32'h2C, 32'h01020304, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, 1'b1);
        xfer(1, 1'b0, 32'h2C, 32'h0, 4'hF, 1'b0);

        // abort: cyc dropped in the second WAIT cycle
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 32'h20; dat = 32'h12345678; sel = 4'hF;
        @(posedge clk); #1;
        chk("abort_w1", 32'(ack[1] | err[1]), 32'd0);
        @(posedge clk); #1;
        chk("abort_w2", 32'(ack[1] | err[1]), 32'd0);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("abort_quiet", 32'(ack[1] | err[1]), 32'd0);
        end
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

        // reset in the middle of WAIT
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 32'h20; dat = 32'hBBBBBBBB; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
        chk("rstw_ack", 32'(ack[1]), 32'd0);
        chk("rstw_err", 32'(err[1]), 32'd0);
        chk("rstw_dat", dat_o[1], 32'd0);
        chk("rstw_dat0", dat_o[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_dat[0] = '0; last_dat[1] = '0;
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

        // out-of-range: err with the feature, aliasing to word 0 without it
        xfer(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        xfer(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        xfer(1, 1'b1, 32'h1020, 32'h77777777, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
